demux1_2_64_buf: RTL
====================

# demux1_2_64_buf

Buffered 1-to-2 datapath demultiplexer: steers one 64-bit input word to one of two output channels, selected by `S`, with a small FIFO per channel and valid/ready handshakes on every port. It is the fan-out counterpart of the 2-to-1 64-bit source multiplexers in the LEGv8 datapath. It sits between a single producer, such as the ALU or memory result bus, and two consumers, such as the write-back and forwarding paths, that may stall independently.

## Interface
- `WIDTH`, 64, data width in bits
- `DEPTH`, 2, entries per output FIFO; power of two, ≥ 2
- `CLK` input 1 — single clock, rising edge
- `RST_N` input 1 — reset, asynchronous, active-low
- `In` input WIDTH — input data word
- `S` input 1 — channel select: 0 → channel A, 1 → channel B
- `InValid` input 1 — producer offers `In`/`S`
- `InReady` output 1 — block accepts this cycle
- `OutA` output WIDTH — channel A head word
- `OutAValid` output 1 — channel A word available
- `OutAReady` input 1 — channel A consumer takes word
- `OutB` output WIDTH — channel B head word
- `OutBValid` output 1 — channel B word available
- `OutBReady` input 1 — channel B consumer takes word
- `CountA` output $clog2(DEPTH)+1 — channel A occupancy
- `CountB` output $clog2(DEPTH)+1 — channel B occupancy

## Operation
- **Two independent FIFOs (A, B).** Each FIFO has `DEPTH` entries, a write pointer, a read pointer ($clog2(DEPTH) bits, wrap modulo DEPTH) and a count (0..DEPTH).
- **Input acceptance.** A push occurs when `InValid && InReady`.
  - The word is written to FIFO A if `S`=0, otherwise to FIFO B.
  - That FIFO's write pointer increments with wrap.
- **`InReady`.** Combinational. `InReady` = (`S`=0 ? `CountA` < DEPTH : `CountB` < DEPTH).
  - It depends on `S`, so the producer must hold `In`/`S` stable while `InValid`=1 and `InReady`=0.
- **Blocking scope.** A full A blocks only A-bound words. B-bound words are still accepted, and vice versa.
- **Pop.** A pop on channel X occurs when `OutXValid && OutXReady`. That FIFO's read pointer increments with wrap.
- **Output signals.**
  - `OutXValid` = (`CountX` != 0).
  - `OutX` = mem_X[rd_ptr_X] when `CountX` != 0, else all zeros.
- **Count update per channel.**
  - Push only: count +1.
  - Pop only: count −1.
  - Push and pop in the same cycle: count unchanged, and both pointers advance.
- **Full FIFO.** `InReady`=0 for that channel even if a pop happens in the same cycle. There is no same-cycle full pass-through.
- **Empty FIFO.** There is no bypass. A word pushed into an empty FIFO appears on the next cycle.
- **Ordering.** Per channel, words leave in acceptance order. There is no ordering relation between A and B.
- **Ready handling.** `OutXReady` while `OutXValid`=0 is ignored.
- **Reset.** `RST_N`=0 asynchronously clears pointers and counts.
  - Resulting outputs: `CountA`=`CountB`=0, `OutAValid`=`OutBValid`=0, `OutA`=`OutB`=0.
  - `InReady` = 1 for either `S` value.
  - Storage contents are not reset.
  - Reset mid-operation discards all buffered words. No pop or push occurs on the reset edge.
- **Release.** The first push is possible on the first rising `CLK` after `RST_N` deasserts.

## Timing
- **Latency.** Input accepted at edge N → `OutXValid`=1 with that word after edge N (visible in cycle N+1), provided the FIFO was empty.
- **Throughput.** One accept per cycle. One pop per channel per cycle. Both channels may pop in the same cycle as a push.
- **Registered outputs.** `OutX`, `OutXValid` and `CountX` change only on the `CLK` edge or on asynchronous reset.
- **Combinational path.** `InReady` is the only combinational output, from `S` and the counts.
- **Sustained full rate.** When `OutXReady` is held high, a continuous stream to channel X sustains full rate with `CountX` ≤ 1.

## Test plan
1. **Reset values.** Assert `RST_N`=0 mid-stream with `CountA`=2 → immediately (no clock) `CountA`=`CountB`=0, both valids 0, `OutA`=`OutB`=0, and `InReady`=1 for either `S` value.
2. **Single word, both channels.**
   - Push `In`=64'hDEAD_BEEF_0000_0001 with `S`=0 → one cycle later `OutAValid`=1, `OutA`=that value, `OutBValid`=0.
   - Repeat with `S`=1 → the word appears on `OutB` only.
3. **Fill, block and wrap on A.**
   - Hold `OutAReady`=0 and push 1, 2 to A → `CountA`=2, then `InReady`=0 for `S`=0.
   - A push of 3 with `S`=1 is accepted into B.
   - Pop A twice → values 1 then 2 in order.
   - Push 4, 5 to A, then pop A → values 4 then 5, exercising pointer wrap.
4. **Simultaneous push and pop.** With `CountB`=1 (value 7), in one cycle push 8 to B and pop B → `CountB` stays 1 and the next `OutB`=8.
5. **Full with pop, no pass-through.** With A full, set `OutAReady`=1 and `InValid`=1, `S`=0 → `InReady`=0 in that cycle and the push is not accepted. On the next cycle `CountA`=1 and `InReady`=1.
6. **Randomized scoreboard.** 10 000 cycles of random `S`, `InValid`, `OutAReady`, `OutBReady` → per-channel order preserved, no loss or duplication, counts never exceed DEPTH.

Source files
------------

// File: rtl/demux1_2_64_buf.sv
// Buffered 1-to-2 demultiplexer: steers each accepted word into one of two
// independent FIFOs, each with its own valid/ready output handshake.
module demux1_2_64_buf #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [WIDTH-1:0]         In,
    input  logic                     S,
    input  logic                     InValid,
    output logic                     InReady,
    output logic [WIDTH-1:0]         OutA,
    output logic                     OutAValid,
    input  logic                     OutAReady,
    output logic [WIDTH-1:0]         OutB,
    output logic                     OutBValid,
    input  logic                     OutBReady,
    output logic [$clog2(DEPTH):0]   CountA,
    output logic [$clog2(DEPTH):0]   CountB
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [PW-1:0]    wr_a, rd_a, wr_b, rd_b;
    logic [CW-1:0]    cnt_a, cnt_b;
    logic             push_a, push_b, pop_a, pop_b;

    // Readiness depends only on the selected channel's pre-edge count, so a
    // full FIFO never accepts even when it is popped in the same cycle.
    always_comb begin
        InReady = S ? (cnt_b != FULL) : (cnt_a != FULL);
        push_a  = InValid && InReady && !S;
        push_b  = InValid && InReady && S;
        pop_a   = (cnt_a != '0) && OutAReady;
        pop_b   = (cnt_b != '0) && OutBReady;
    end

    always_comb begin
        OutAValid = (cnt_a != '0);
        OutBValid = (cnt_b != '0);
        OutA      = OutAValid ? mem_a[rd_a] : '0;
        OutB      = OutBValid ? mem_b[rd_b] : '0;
        CountA    = cnt_a;
        CountB    = cnt_b;
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge CLK) begin
        if (push_a) mem_a[wr_a] <= In;
        if (push_b) mem_b[wr_b] <= In;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_a  <= '0;
            rd_a  <= '0;
            cnt_a <= '0;
            wr_b  <= '0;
            rd_b  <= '0;
            cnt_b <= '0;
        end else begin
            if (push_a) wr_a <= wr_a + PW'(1);
            if (pop_a)  rd_a <= rd_a + PW'(1);
            if (push_b) wr_b <= wr_b + PW'(1);
            if (pop_b)  rd_b <= rd_b + PW'(1);
            case ({push_a, pop_a})
                2'b10:   cnt_a <= cnt_a + CW'(1);
                2'b01:   cnt_a <= cnt_a - CW'(1);
                default: cnt_a <= cnt_a;
            endcase
            case ({push_b, pop_b})
                2'b10:   cnt_b <= cnt_b + CW'(1);
                2'b01:   cnt_b <= cnt_b - CW'(1);
                default: cnt_b <= cnt_b;
            endcase
        end
    end

endmodule
